ship_placer: RTL and testbench

SHIP_PLACER -- requirements
Module: ship_placer

---
 rtl/ship_placer_pkg.sv | 40 ++++
 rtl/ship_tile_addr.sv | 33 +++
 rtl/ship_placer.sv | 145 ++++++++++++++
 tb/tb_ship_placer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ship_placer_pkg.sv
// Shared ship-placement definitions: board and fleet sizing, direction codes,
// button bit positions and the fleet size table.
package ship_placer_pkg;
  localparam int SP_BOARD_DIM  = 10;
  localparam int SP_FLEET_SIZE = 5;

  localparam int BTN_PLACE = 5;
  localparam int BTN_ROT   = 4;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  typedef enum logic [3:0] {
    DIR_N = 4'd1, DIR_E = 4'd2, DIR_S = 4'd4, DIR_W = 4'd8
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_EDIT, ST_CHECK, ST_WRITE, ST_DONE
  } state_e;

  // Ship tile count minus one, by ship index (sizes 5,4,3,3,2).
  function automatic logic [3:0] ship_len(input logic [2:0] idx);
    case (idx)
      3'd0:       return 4'd4;
      3'd1:       return 4'd3;
      3'd2, 3'd3: return 4'd2;
      default:    return 4'd1;
    endcase
  endfunction

  function automatic dir_e rotate_cw(input dir_e d);
    case (d)
      DIR_N:   return DIR_E;
      DIR_E:   return DIR_S;
      DIR_S:   return DIR_W;
      default: return DIR_N;
    endcase
  endfunction
endpackage

// File: rtl/ship_tile_addr.sv
// Tile k of a ship anchored at (cx,cy): coordinates plus an in-bounds flag.
// Signed 5-bit intermediates so stepping below zero is seen, not wrapped.
module ship_tile_addr import ship_placer_pkg::*; #(
  parameter int BOARD_DIM = SP_BOARD_DIM
) (
  input  logic [3:0] cx,
  input  logic [3:0] cy,
  input  dir_e       orient,
  input  logic [3:0] k,
  output logic [3:0] tx,
  output logic [3:0] ty,
  output logic       in_bounds
);
  localparam logic signed [4:0] DIM_S = 5'(BOARD_DIM);

  logic signed [4:0] sx, sy, sk;

  always_comb begin
    sx = signed'({1'b0, cx});
    sy = signed'({1'b0, cy});
    sk = signed'({1'b0, k});
    case (orient)
      DIR_N:   sy = sy - sk;
      DIR_E:   sx = sx + sk;
      DIR_S:   sy = sy + sk;
      default: sx = sx - sk;
    endcase
  end

  assign in_bounds = (sx >= 5'sd0) && (sx < DIM_S) && (sy >= 5'sd0) && (sy < DIM_S);
  assign tx = sx[3:0];
  assign ty = sy[3:0];
endmodule

// File: rtl/ship_placer.sv
// Battleship fleet placement: cursor editing, overlap check via board reads,
// then a tile-by-tile write of the accepted ship.
module ship_placer import ship_placer_pkg::*; #(
  parameter int BOARD_DIM  = SP_BOARD_DIM,
  parameter int FLEET_SIZE = SP_FLEET_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] btn,
  output logic [7:0] cursor,
  output logic [3:0] orientation,
  output logic [3:0] length,
  output logic       ghost_en,
  output logic [7:0] board_addr,
  input  logic [2:0] board_rd_data,
  output logic       board_wr_en,
  output logic [2:0] board_wr_data,
  output logic       busy,
  output logic       reject,
  output logic       done
);
  localparam logic [3:0] DIM_MAX  = 4'(BOARD_DIM - 1);
  localparam logic [2:0] LAST_IDX = 3'(FLEET_SIZE - 1);

  state_e     state_q, state_d;
  logic [3:0] cx_q, cx_d, cy_q, cy_d;
  dir_e       orient_q, orient_d;
  logic [3:0] len_q, len_d, k_q, k_d;
  logic [2:0] idx_q, idx_d;
  logic       hit_q, hit_d, reject_q, reject_d;

  logic [3:0] k_sel, tx, ty;
  logic       tile_ok;

  // In EDIT the address unit evaluates the final tile for the bounds check.
  assign k_sel = (state_q == ST_EDIT) ? len_q : k_q;

  ship_tile_addr #(.BOARD_DIM(BOARD_DIM)) u_tile (
    .cx(cx_q), .cy(cy_q), .orient(orient_q), .k(k_sel),
    .tx(tx), .ty(ty), .in_bounds(tile_ok)
  );

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    orient_d = orient_q;
    len_d    = len_q;
    idx_d    = idx_q;
    k_d      = k_q;
    hit_d    = hit_q;
    reject_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) begin
        state_d  = ST_EDIT;
        cx_d     = '0;
        cy_d     = '0;
        orient_d = DIR_E;
        idx_d    = '0;
        len_d    = ship_len(3'd0);
      end
      ST_EDIT: begin
        if (btn[BTN_PLACE]) begin
          if (!tile_ok) reject_d = 1'b1;
          else begin
            state_d = ST_CHECK;
            k_d     = '0;
            hit_d   = 1'b0;
          end
        end
        else if (btn[BTN_ROT])   orient_d = rotate_cw(orient_q);
        else if (btn[BTN_UP])    begin if (cy_q != 4'd0)    cy_d = cy_q - 4'd1; end
        else if (btn[BTN_DOWN])  begin if (cy_q < DIM_MAX)  cy_d = cy_q + 4'd1; end
        else if (btn[BTN_LEFT])  begin if (cx_q != 4'd0)    cx_d = cx_q - 4'd1; end
        else if (btn[BTN_RIGHT]) begin if (cx_q < DIM_MAX)  cx_d = cx_q + 4'd1; end
      end
      ST_CHECK: begin
        // Read data trails the address by a cycle, so tile k-1 is sampled at step k.
        k_d = k_q + 4'd1;
        if (k_q != 4'd0 && board_rd_data != 3'd0) hit_d = 1'b1;
        if (k_q == len_q + 4'd1) begin
          k_d = '0;
          if (hit_d) begin
            state_d  = ST_EDIT;
            reject_d = 1'b1;
          end
          else state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        k_d = k_q + 4'd1;
        if (k_q == len_q) begin
          k_d      = '0;
          idx_d    = idx_q + 3'd1;
          cx_d     = '0;
          cy_d     = '0;
          orient_d = DIR_E;
          if (idx_q == LAST_IDX) state_d = ST_DONE;
          else begin
            state_d = ST_EDIT;
            len_d   = ship_len(idx_q + 3'd1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      orient_q <= DIR_E;
      len_q    <= ship_len(3'd0);
      idx_q    <= '0;
      k_q      <= '0;
      hit_q    <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      orient_q <= orient_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      k_q      <= k_d;
      hit_q    <= hit_d;
      reject_q <= reject_d;
    end
  end

  assign cursor        = {cx_q, cy_q};
  assign orientation   = orient_q;
  assign length        = len_q;
  assign ghost_en      = (state_q == ST_EDIT);
  assign busy          = (state_q == ST_CHECK) || (state_q == ST_WRITE);
  assign reject        = reject_q;
  assign done          = (state_q == ST_DONE);
  assign board_wr_en   = (state_q == ST_WRITE);
  assign board_wr_data = (state_q == ST_WRITE) ? idx_q + 3'd1 : 3'd0;
  assign board_addr    = (state_q == ST_WRITE || (state_q == ST_CHECK && k_q <= len_q))
                         ? {tx, ty} : 8'h00;
endmodule

// File: tb/tb_ship_placer.sv
// Randomized bench for ship_placer: a schedule-based fleet model predicts every
// output each cycle, with directed scenarios pinned by literal expectations.
module tb_ship_placer;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [5:0] btn = '0;
  logic [7:0] cursor, board_addr;
  logic [3:0] orientation, length;
  logic       ghost_en, board_wr_en, busy, reject, done;
  logic [2:0] board_rd_data, board_wr_data;

  ship_placer dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .cursor(cursor),
    .orientation(orientation), .length(length), .ghost_en(ghost_en),
    .board_addr(board_addr), .board_rd_data(board_rd_data),
    .board_wr_en(board_wr_en), .board_wr_data(board_wr_data),
    .busy(busy), .reject(reject), .done(done)
  );

  always #5 clk = ~clk;

  // Board memory: one-cycle read latency, preload/clear ports for the bench.
  bit [2:0]   mem [256];
  bit         pl_en = 1'b0, pl_clr = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [2:0] pl_val = '0;
  always @(posedge clk) begin
    if (pl_clr) for (int i = 0; i < 256; i++) mem[i] <= 3'd0;
    else if (pl_en) mem[pl_addr] <= pl_val;
    else if (board_wr_en) mem[board_addr] <= board_wr_data;
    board_rd_data <= mem[board_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: ship geometry by arithmetic, busy phases as a queue of cycles.
  typedef struct { bit wr; bit achk; int addr; int data; } rec_t;
  rec_t plan[$];
  int   post_act;
  int   m_mode, m_x, m_y, m_dir, m_idx;   // mode 0 idle, 1 edit, 2 done; dir 0..3 = N,E,S,W
  bit   m_rej;
  int   mb [256];
  int   sizes [5] = '{5, 4, 3, 3, 2};
  int   dxs [4]   = '{0, 1, 0, -1};
  int   dys [4]   = '{-1, 0, 1, 0};

  bit chk_en = 1'b0;
  int e_cursor, e_orient, e_len, e_ghost, e_busy, e_rej, e_done, e_wr, e_achk, e_addr, e_data;

  task automatic do_place();
    int L, fx, fy, a;
    bit hit;
    L  = sizes[m_idx] - 1;
    fx = m_x + dxs[m_dir] * L;
    fy = m_y + dys[m_dir] * L;
    if (fx < 0 || fx > 9 || fy < 0 || fy > 9) begin
      m_rej = 1'b1;
      return;
    end
    hit = 1'b0;
    for (int k = 0; k <= L; k++) begin
      a = (m_x + dxs[m_dir] * k) * 16 + (m_y + dys[m_dir] * k);
      if (mb[a] != 0) hit = 1'b1;
      plan.push_back('{1'b0, 1'b1, a, 0});
    end
    plan.push_back('{1'b0, 1'b0, 0, 0});
    if (hit) post_act = 1;
    else begin
      for (int k = 0; k <= L; k++) begin
        a = (m_x + dxs[m_dir] * k) * 16 + (m_y + dys[m_dir] * k);
        plan.push_back('{1'b1, 1'b1, a, m_idx + 1});
      end
      post_act = 2;
    end
  endtask

  task automatic model_step(input bit r, input bit s, input logic [5:0] b);
    rec_t c;
    bit   was_busy;
    m_rej    = 1'b0;
    was_busy = (plan.size() > 0);
    if (was_busy) begin
      c = plan.pop_front();
      if (c.wr) mb[c.addr] = c.data;
    end
    if (r) begin
      m_mode = 0; m_x = 0; m_y = 0; m_dir = 1; m_idx = 0;
      plan.delete();
      return;
    end
    if (was_busy) begin
      if (plan.size() == 0) begin
        if (post_act == 1) m_rej = 1'b1;
        else begin
          m_idx++; m_x = 0; m_y = 0; m_dir = 1;
          m_mode = (m_idx == 5) ? 2 : 1;
        end
      end
      return;
    end
    if (m_mode != 1) begin
      if (s) begin m_mode = 1; m_idx = 0; m_x = 0; m_y = 0; m_dir = 1; end
    end
    else if (b[5]) do_place();
    else if (b[4]) m_dir = (m_dir + 1) % 4;
    else if (b[3]) begin if (m_y > 0) m_y--; end
    else if (b[2]) begin if (m_y < 9) m_y++; end
    else if (b[1]) begin if (m_x > 0) m_x--; end
    else if (b[0]) begin if (m_x < 9) m_x++; end
  endtask

  task automatic calc_exp();
    e_cursor = m_x * 16 + m_y;
    e_orient = 1 << m_dir;
    e_len    = sizes[(m_idx < 5) ? m_idx : 4] - 1;
    if (plan.size() > 0) begin
      e_busy = 1; e_ghost = 0; e_rej = 0; e_done = 0;
      e_wr = int'(plan[0].wr); e_achk = int'(plan[0].achk);
      e_addr = plan[0].addr; e_data = plan[0].data;
    end else begin
      e_busy = 0; e_wr = 0; e_achk = 1; e_addr = 0; e_data = 0;
      e_ghost = (m_mode == 1) ? 1 : 0;
      e_rej   = int'(m_rej);
      e_done  = (m_mode == 2) ? 1 : 0;
    end
  endtask

  int wr_cyc[$], wr_addr[$], wr_dat[$];

  always @(negedge clk) begin
    if (board_wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(board_addr));
      wr_dat.push_back(int'(board_wr_data));
    end
    if (chk_en) begin
      chk("cursor", int'(cursor), e_cursor);
      chk("orientation", int'(orientation), e_orient);
      chk("length", int'(length), e_len);
      chk("ghost_en", int'(ghost_en), e_ghost);
      chk("busy", int'(busy), e_busy);
      chk("reject", int'(reject), e_rej);
      chk("done", int'(done), e_done);
      chk("board_wr_en", int'(board_wr_en), e_wr);
      if (e_wr != 0) chk("board_wr_data", int'(board_wr_data), e_data);
      if (e_achk != 0) chk("board_addr", int'(board_addr), e_addr);
    end
  end

  task automatic tick(input bit r, input bit s, input logic [5:0] b);
    rst = r; start = s; btn = b;
    @(posedge clk); #1;
    model_step(r, s, b);
    calc_exp();
    rst = 1'b0; start = 1'b0; btn = '0; pl_en = 1'b0; pl_clr = 1'b0;
  endtask

  task automatic rand_tick(input bit allow_rst, input bit allow_start);
    logic [5:0] b;
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      3:       b = 6'h20;
      4:       b = 6'h10;
      5:       b = 6'h08;
      6:       b = 6'h04;
      7:       b = 6'h02;
      8:       b = 6'h01;
      9:       b = 6'($urandom);
      default: b = 6'h00;
    endcase
    tick(allow_rst && ($urandom_range(0, 199) == 0),
         allow_start && ($urandom_range(0, 49) == 0), b);
  endtask

  task automatic clear_wr();
    wr_cyc.delete(); wr_addr.delete(); wr_dat.delete();
  endtask

  int t0;
  int lit35 [5] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40};

  initial begin
    tick(1'b1, 1'b0, 6'h00);
    tick(1'b1, 1'b0, 6'h00);
    pl_clr = 1'b1;
    tick(1'b0, 1'b0, 6'h00);
    chk_en = 1'b1;
    chk("rst_cursor", int'(cursor), 0);
    chk("rst_orient", int'(orientation), 2);
    chk("rst_length", int'(length), 4);
    chk("rst_ghost", int'(ghost_en), 0);
    chk("rst_done", int'(done), 0);

    // First ship placed at (0,0) facing east on an empty board.
    tick(1'b0, 1'b1, 6'h00);
    clear_wr();
    t0 = cyc;
    tick(1'b0, 1'b0, 6'h20);
    repeat (12) tick(1'b0, 1'b0, 6'h00);
    chk("ship0_write_count", wr_cyc.size(), 5);
    for (int i = 0; i < 5 && i < wr_cyc.size(); i++) begin
      chk("ship0_write_cycle", wr_cyc[i] - t0, 7 + i);
      chk("ship0_write_addr", wr_addr[i], lit35[i]);
      chk("ship0_write_data", wr_dat[i], 1);
    end
    chk("ship1_length", int'(length), 3);

    // North from (0,2) with a 4-tile ship leaves the board.
    repeat (2) tick(1'b0, 1'b0, 6'h04);
    repeat (3) tick(1'b0, 1'b0, 6'h10);
    clear_wr();
    tick(1'b0, 1'b0, 6'h20);
    chk("oob_reject", int'(reject), 1);
    chk("oob_addr", int'(board_addr), 0);
    chk("oob_edit", int'(ghost_en), 1);
    tick(1'b0, 1'b0, 6'h00);
    chk("oob_pulse_end", int'(reject), 0);
    chk("oob_no_write", wr_cyc.size(), 0);

    // Occupied tile (2,1) blocks a south-facing ship anchored there.
    mb[8'h21] = 2;
    pl_en = 1'b1; pl_addr = 8'h21; pl_val = 3'd2;
    tick(1'b0, 1'b0, 6'h00);
    repeat (2) tick(1'b0, 1'b0, 6'h01);
    tick(1'b0, 1'b0, 6'h08);
    repeat (2) tick(1'b0, 1'b0, 6'h10);
    clear_wr();
    tick(1'b0, 1'b0, 6'h20);
    repeat (5) tick(1'b0, 1'b0, 6'h00);
    chk("overlap_reject", int'(reject), 1);
    chk("overlap_cursor", int'(cursor), 8'h21);
    chk("overlap_orient", int'(orientation), 4);
    tick(1'b0, 1'b0, 6'h00);
    chk("overlap_no_write", wr_cyc.size(), 0);

    // Clamp at the board edge and button priority.
    repeat (10) tick(1'b0, 1'b0, 6'h08);
    repeat (12) tick(1'b0, 1'b0, 6'h04);
    chk("clamp_ymax", int'(cursor[3:0]), 9);
    tick(1'b0, 1'b0, 6'h0A);
    chk("up_over_left", int'(cursor), 8'h28);

    // Finish the fleet with random editing.
    for (int i = 0; i < 4000 && done !== 1'b1; i++) rand_tick(1'b0, 1'b0);
    chk("fleet_done", int'(done), 1);
    repeat (30) rand_tick(1'b0, 1'b0);
    chk("done_hold", int'(done), 1);
    chk("done_cursor", int'(cursor), 0);

    // Reset landing on the second write cycle of a fresh game.
    for (int i = 0; i < 256; i++) mb[i] = 0;
    pl_clr = 1'b1;
    tick(1'b0, 1'b0, 6'h00);
    tick(1'b0, 1'b1, 6'h00);
    clear_wr();
    tick(1'b0, 1'b0, 6'h20);
    repeat (7) tick(1'b0, 1'b0, 6'h00);
    chk("rstw_writing", int'(board_wr_en), 1);
    tick(1'b1, 1'b0, 6'h00);
    chk("rstw_wr_en", int'(board_wr_en), 0);
    chk("rstw_busy", int'(busy), 0);
    chk("rstw_length", int'(length), 4);
    chk("rstw_orient", int'(orientation), 2);
    tick(1'b0, 1'b0, 6'h00);
    chk("rstw_write_count", wr_cyc.size(), 2);

    // Free-running game with occasional start and reset pulses.
    tick(1'b0, 1'b1, 6'h00);
    repeat (1500) rand_tick(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
